// File: rtl/synth_timing_pkg.sv
// Shared timing constants for the synth's rate timers and the
// channel-index width helper used by the compare scheduler.
package synth_timing_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int NCH_DEF      = 4;
    localparam int TB_MOD_DEF   = 500000;
    localparam int PERIOD_100HZ = CLK_HZ / (NCH_DEF * 100);

    function automatic int chw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/compare_scheduler_mod_adder.sv
// Combinational (a + b) mod TB_MOD for operands already below TB_MOD.
module mod_adder #(
    parameter int W      = 19,
    parameter int TB_MOD = 500000
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam logic [W:0] MOD = (W+1)'(TB_MOD);

    logic [W:0] raw;

    // The W+1 bit sum cannot overflow, so one conditional subtract suffices.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = W'((raw >= MOD) ? raw - MOD : raw);
    end

endmodule

// File: rtl/compare_scheduler.sv
// One equality comparator time-multiplexed over NCH timer channels against a
// shared timebase that advances once per full channel scan.
module compare_scheduler
    import synth_timing_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int W      = 19,
    parameter int TB_MOD = TB_MOD_DEF,
    parameter int CHW    = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_period,
    input  logic           cfg_enable,
    output logic [NCH-1:0] tick,
    output logic [W-1:0]   tb,
    output logic [CHW-1:0] slot
);

    localparam logic [W-1:0]   TB_LAST   = W'(TB_MOD - 1);
    localparam logic [W:0]     TB_MOD_X  = (W+1)'(TB_MOD);
    localparam logic [CHW-1:0] SLOT_LAST = CHW'(NCH - 1);

    logic [W-1:0]   period_q   [NCH];
    logic [W-1:0]   deadline_q [NCH];
    logic [NCH-1:0] enable_q;

    logic           accept;
    logic           match;
    logic [W-1:0]   cfg_period_sat;
    logic [W-1:0]   load_deadline;
    logic [W-1:0]   reload_deadline;

    // A write is refused only while its channel is in the compare slot.
    always_comb begin
        cfg_ready      = !rst && (slot != cfg_ch);
        accept         = cfg_valid && cfg_ready;
        match          = enable_q[slot] && (tb == deadline_q[slot]);
        cfg_period_sat = ({1'b0, cfg_period} >= TB_MOD_X) ? TB_LAST : cfg_period;
    end

    // Load and reload can fire in the same cycle for different channels,
    // so each path gets its own adder instance.
    mod_adder #(.W(W), .TB_MOD(TB_MOD)) u_load_add (
        .a   (tb),
        .b   (cfg_period_sat),
        .sum (load_deadline)
    );

    mod_adder #(.W(W), .TB_MOD(TB_MOD)) u_reload_add (
        .a   (deadline_q[slot]),
        .b   (period_q[slot]),
        .sum (reload_deadline)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            tb       <= '0;
            tick     <= '0;
            enable_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                period_q[i]   <= '0;
                deadline_q[i] <= '0;
            end
        end else begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            if (slot == SLOT_LAST) begin
                tb <= (tb == TB_LAST) ? '0 : tb + 1'b1;
            end
            tick <= match ? (NCH'(1) << slot) : '0;
            if (match) begin
                deadline_q[slot] <= reload_deadline;
            end
            // A zero period can never be reached again, so it parks the channel.
            if (accept) begin
                period_q[cfg_ch]   <= cfg_period_sat;
                enable_q[cfg_ch]   <= cfg_enable && (cfg_period != '0);
                deadline_q[cfg_ch] <= load_deadline;
            end
        end
    end

endmodule

// File: tb/tb_compare_scheduler.sv
// Bench for compare_scheduler: absolute-cycle tick model checked every cycle,
// plus directed scenarios with hand-computed tick times.
module tb_compare_scheduler;

    localparam int NCH    = 4;
    localparam int W      = 5;
    localparam int TB_MOD = 16;
    localparam int CHW    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_period;
    logic           cfg_enable;
    logic [NCH-1:0] tick;
    logic [W-1:0]   tb;
    logic [CHW-1:0] slot;

    int checks = 0;
    int errors = 0;

    // Model: cycle index since reset release, and per channel the absolute
    // cycle of its next compare hit.
    int cyc = 0;
    bit rst_prev = 1'b0;
    int m_en     [NCH];
    int m_period [NCH];
    int m_cmp    [NCH];
    int exp_tick = 0;
    int log_cyc [$];
    int log_ch  [$];

    compare_scheduler #(.NCH(NCH), .W(W), .TB_MOD(TB_MOD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_enable (cfg_enable),
        .tick       (tick),
        .tb         (tb),
        .slot       (slot)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int count_ticks(input int ch);
        int c = 0;
        foreach (log_cyc[i]) if (ch < 0 || log_ch[i] == ch) c++;
        return c;
    endfunction

    function automatic int nth_tick(input int ch, input int k);
        int c = 0;
        foreach (log_cyc[i]) begin
            if (log_ch[i] == ch) begin
                if (c == k) return log_cyc[i];
                c++;
            end
        end
        return -1;
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        int s;
        int next_tick;
        int p;
        if (rst) begin
            checkOutput("cfg_ready_in_reset", int'(cfg_ready), 0);
            if (rst_prev) begin
                checkOutput("tick_in_reset", int'(tick), 0);
                checkOutput("tb_in_reset", int'(tb), 0);
                checkOutput("slot_in_reset", int'(slot), 0);
            end
            cyc = 0;
            exp_tick = 0;
            for (int i = 0; i < NCH; i++) begin
                m_en[i] = 0;
                m_period[i] = 0;
                m_cmp[i] = 0;
            end
            log_cyc.delete();
            log_ch.delete();
            rst_prev = 1'b1;
        end else begin
            s = cyc % NCH;
            checkOutput("tb", int'(tb), (cyc / NCH) % TB_MOD);
            checkOutput("slot", int'(slot), s);
            checkOutput("tick", int'(tick), exp_tick);
            checkOutput("cfg_ready", int'(cfg_ready), (int'(cfg_ch) != s) ? 1 : 0);
            next_tick = 0;
            if (m_en[s] != 0 && m_cmp[s] == cyc) begin
                next_tick = 1 << s;
                m_cmp[s] += m_period[s] * NCH;
                log_cyc.push_back(cyc + 1);
                log_ch.push_back(s);
            end
            if (cfg_valid && int'(cfg_ch) != s) begin
                p = (int'(cfg_period) >= TB_MOD) ? TB_MOD - 1 : int'(cfg_period);
                m_period[cfg_ch] = p;
                m_en[cfg_ch] = (p != 0 && cfg_enable) ? 1 : 0;
                m_cmp[cfg_ch] = ((cyc / NCH) + p) * NCH + int'(cfg_ch);
            end
            exp_tick = next_tick;
            cyc++;
            rst_prev = 1'b0;
        end
    end

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input int period, input bit enable, output int acc_cycle);
        cfg_ch = CHW'(ch);
        cfg_period = W'(period);
        cfg_enable = enable;
        cfg_valid = 1'b1;
        acc_cycle = -1;
        for (int k = 0; k < 4 && acc_cycle < 0; k++) begin
            #1;
            if (cfg_ready) acc_cycle = cyc;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        if (acc_cycle < 0) checkOutput("cfg_accept_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        $display("[TB] compare_scheduler bench starting");
        rst = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = '0;
        cfg_period = W'(5);
        cfg_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_valid = 1'b0;

        // Period 3 on ch0, then a write to ch2 that collides with slot 2.
        waitUntil(1);
        applyStimulus(0, 3, 1'b1, acc);
        checkOutput("ch0_accept_cycle", acc, 1);
        applyStimulus(2, 5, 1'b1, acc);
        checkOutput("ch2_stall_accept_cycle", acc, 3);
        waitUntil(45);
        checkOutput("ch0_tick_1", nth_tick(0, 0), 13);
        checkOutput("ch0_tick_2", nth_tick(0, 1), 25);
        checkOutput("ch0_tick_3", nth_tick(0, 2), 37);
        checkOutput("ch2_tick_1", nth_tick(2, 0), 23);
        checkOutput("ch1_idle_ticks", count_ticks(1), 0);

        // Period 10 on ch1: deadline wraps past the timebase modulus.
        doReset(2);
        waitUntil(1);
        applyStimulus(1, 10, 1'b1, acc);
        waitUntil(125);
        checkOutput("ch1_wrap_tick_1", nth_tick(1, 0), 42);
        checkOutput("ch1_wrap_tick_2", nth_tick(1, 1), 82);
        checkOutput("ch1_wrap_tick_3", nth_tick(1, 2), 122);
        checkOutput("ch1_wrap_count", count_ticks(1), 3);

        // Equal deadlines, saturation, zero period, late disable, mid-run reset.
        doReset(2);
        applyStimulus(1, 3, 1'b1, acc);
        applyStimulus(0, 3, 1'b1, acc);
        applyStimulus(3, 20, 1'b1, acc);
        applyStimulus(2, 0, 1'b1, acc);
        waitUntil(49);
        applyStimulus(0, 3, 1'b0, acc);
        checkOutput("ch0_disable_accept_cycle", acc, 49);
        waitUntil(75);
        checkOutput("ch0_same_window_tick", nth_tick(0, 0), 13);
        checkOutput("ch1_same_window_tick", nth_tick(1, 0), 14);
        checkOutput("ch0_last_tick", nth_tick(0, 3), 49);
        checkOutput("ch0_ticks_after_disable", count_ticks(0), 4);
        checkOutput("ch2_zero_period_ticks", count_ticks(2), 0);
        checkOutput("ch3_saturated_tick", nth_tick(3, 0), 64);
        doReset(2);
        waitUntil(30);
        checkOutput("ticks_after_midrun_reset", count_ticks(-1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
